// File: rtl/bist_pkg.sv
// Shared types and the Galois shift step used by the BIST LFSR and MISR.
package bist_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int MAX_W = 32;

    // Right-shift Galois step; callers zero-extend narrower operands and truncate the result.
    function automatic logic [MAX_W-1:0] galois_step(input logic [MAX_W-1:0] state,
                                                     input logic [MAX_W-1:0] poly,
                                                     input logic [MAX_W-1:0] din);
        return (state >> 1) ^ (state[0] ? poly : '0) ^ din;
    endfunction

endpackage

// File: rtl/galois_shift_reg.sv
// Loadable Galois shift register: serves as the stimulus LFSR (din=0) and as the response MISR.
module galois_shift_reg
    import bist_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] stepped;

    assign stepped = WIDTH'(galois_step(MAX_W'(value), MAX_W'(POLY), MAX_W'(din)));

    always_ff @(posedge clk) begin
        if (load) begin
            value <= SEED;
        end else if (enable) begin
            value <= stepped;
        end
    end

endmodule

// File: rtl/bist_controller.sv
// BIST wrapper: LFSR stimulus, capture-delay line, MISR compaction and run sequencing.
// Optional BIST_SIGNATURE_CHECK_EN adds a registered PASS flag compared against EXPECTED_SIGNATURE.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               WIDTH              = 16,
    parameter int               PATTERN_COUNT      = 1000,
    parameter logic [WIDTH-1:0] LFSR_SEED          = 16'hACE1,
    parameter logic [WIDTH-1:0] LFSR_POLY          = 16'hB400,
    parameter logic [WIDTH-1:0] MISR_POLY          = 16'hB400,
    parameter int               CAPTURE_LATENCY    = 1,
    parameter logic [WIDTH-1:0] EXPECTED_SIGNATURE = '0
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             START,
    output logic [WIDTH-1:0] PATTERN_OUT,
    output logic             PATTERN_VALID,
    input  logic [WIDTH-1:0] RESPONSE_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SIGNATURE
`ifdef BIST_SIGNATURE_CHECK_EN
   ,output logic             PASS
`endif
);

    localparam int CNT_W   = $clog2(PATTERN_COUNT + 1);
    localparam int DRAIN_W = 3;

    state_t             state, state_next;
    logic               start_run;
    logic               cap_vld;
    logic [CNT_W-1:0]   pat_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [WIDTH-1:0]   lfsr_val;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_next = S_RUN;
                    start_run  = 1'b1;
                end
            end
            S_RUN: begin
                if (pat_cnt == CNT_W'(PATTERN_COUNT - 1)) begin
                    state_next = (CAPTURE_LATENCY == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_W'(CAPTURE_LATENCY - 1)) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Pattern counter saturates at PATTERN_COUNT so it can never alias back to a live index.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N || start_run) begin
            pat_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == S_RUN && pat_cnt != CNT_W'(PATTERN_COUNT)) begin
                pat_cnt <= pat_cnt + 1'b1;
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    assign PATTERN_VALID = (state == S_RUN);
    assign PATTERN_OUT   = PATTERN_VALID ? lfsr_val : '0;
    assign BUSY          = (state == S_RUN) || (state == S_DRAIN);
    assign DONE          = (state == S_DONE);

    // Capture valid follows PATTERN_VALID through the same depth as the CUT pipeline.
    generate
        if (CAPTURE_LATENCY == 0) begin : g_no_delay
            assign cap_vld = PATTERN_VALID;
        end else begin : g_delay
            logic [CAPTURE_LATENCY-1:0] vld_dly;
            always_ff @(posedge CLOCK) begin
                if (!RESET_N) begin
                    vld_dly <= '0;
                end else begin
                    vld_dly <= CAPTURE_LATENCY'({vld_dly, PATTERN_VALID});
                end
            end
            assign cap_vld = vld_dly[CAPTURE_LATENCY-1];
        end
    endgenerate

    galois_shift_reg #(
        .WIDTH (WIDTH),
        .POLY  (LFSR_POLY),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk    (CLOCK),
        .load   (!RESET_N || start_run),
        .enable (state == S_RUN),
        .din    ('0),
        .value  (lfsr_val)
    );

    galois_shift_reg #(
        .WIDTH (WIDTH),
        .POLY  (MISR_POLY),
        .SEED  ('0)
    ) u_misr (
        .clk    (CLOCK),
        .load   (!RESET_N || start_run),
        .enable (cap_vld),
        .din    (RESPONSE_IN),
        .value  (SIGNATURE)
    );

`ifdef BIST_SIGNATURE_CHECK_EN
    // The final MISR update lands on the same edge that enters DONE, so compare the next value.
    logic [WIDTH-1:0] misr_step;

    assign misr_step = WIDTH'(galois_step(MAX_W'(SIGNATURE), MAX_W'(MISR_POLY), MAX_W'(RESPONSE_IN)));

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            PASS <= 1'b0;
        end else if (state_next == S_DONE) begin
            if (state != S_DONE) begin
                PASS <= ((cap_vld ? misr_step : SIGNATURE) == EXPECTED_SIGNATURE);
            end
        end else begin
            PASS <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: fixed spec scenarios plus randomized runs vs. a reference model.
module tb_bist_controller;

    localparam int RW = 8;
    localparam int RN = 20;
    localparam int RL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b, start_c, start_r;
    logic [3:0] pat_a, resp_a, sig_a, pat_a6, resp_a6, sig_a6;
    logic [3:0] pat_b, resp_b, sig_b, pat_c, resp_c, sig_c;
    logic [RW-1:0] pat_r, resp_r, sig_r;
    logic pv_a, busy_a, done_a, pv_a6, busy_a6, done_a6;
    logic pv_b, busy_b, done_b, pv_c, busy_c, done_c, pv_r, busy_r, done_r;
`ifdef BIST_SIGNATURE_CHECK_EN
    logic pass_a, pass_a6, pass_b, pass_c, pass_r;
`endif
    logic [3:0] cut1 = '0, cut2 = '0;

    int n_tests = 0;
    int n_fail  = 0;

    assign resp_a  = ~pat_a;
    assign resp_a6 = ~pat_a6;
    assign resp_b  = ~pat_b;
    assign resp_c  = cut2;

    // Two-stage registered inverter CUT for the latency-2 instance.
    always_ff @(posedge clk) begin
        cut1 <= ~pat_c;
        cut2 <= cut1;
    end

    bist_controller #(.WIDTH(4), .PATTERN_COUNT(4), .LFSR_SEED(4'h1), .LFSR_POLY(4'hC),
                      .MISR_POLY(4'hC), .CAPTURE_LATENCY(0), .EXPECTED_SIGNATURE(4'h5)) dut_a (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_a), .PATTERN_OUT(pat_a), .PATTERN_VALID(pv_a),
        .RESPONSE_IN(resp_a), .BUSY(busy_a), .DONE(done_a), .SIGNATURE(sig_a)
`ifdef BIST_SIGNATURE_CHECK_EN
       ,.PASS(pass_a)
`endif
    );

    bist_controller #(.WIDTH(4), .PATTERN_COUNT(4), .LFSR_SEED(4'h1), .LFSR_POLY(4'hC),
                      .MISR_POLY(4'hC), .CAPTURE_LATENCY(0), .EXPECTED_SIGNATURE(4'h6)) dut_a6 (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_a), .PATTERN_OUT(pat_a6), .PATTERN_VALID(pv_a6),
        .RESPONSE_IN(resp_a6), .BUSY(busy_a6), .DONE(done_a6), .SIGNATURE(sig_a6)
`ifdef BIST_SIGNATURE_CHECK_EN
       ,.PASS(pass_a6)
`endif
    );

    bist_controller #(.WIDTH(4), .PATTERN_COUNT(16), .LFSR_SEED(4'h1), .LFSR_POLY(4'hC),
                      .MISR_POLY(4'hC), .CAPTURE_LATENCY(0), .EXPECTED_SIGNATURE(4'h0)) dut_b (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_b), .PATTERN_OUT(pat_b), .PATTERN_VALID(pv_b),
        .RESPONSE_IN(resp_b), .BUSY(busy_b), .DONE(done_b), .SIGNATURE(sig_b)
`ifdef BIST_SIGNATURE_CHECK_EN
       ,.PASS(pass_b)
`endif
    );

    bist_controller #(.WIDTH(4), .PATTERN_COUNT(4), .LFSR_SEED(4'h1), .LFSR_POLY(4'hC),
                      .MISR_POLY(4'hC), .CAPTURE_LATENCY(2), .EXPECTED_SIGNATURE(4'h5)) dut_c (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_c), .PATTERN_OUT(pat_c), .PATTERN_VALID(pv_c),
        .RESPONSE_IN(resp_c), .BUSY(busy_c), .DONE(done_c), .SIGNATURE(sig_c)
`ifdef BIST_SIGNATURE_CHECK_EN
       ,.PASS(pass_c)
`endif
    );

    bist_controller #(.WIDTH(RW), .PATTERN_COUNT(RN), .LFSR_SEED(8'h5A), .LFSR_POLY(8'hB8),
                      .MISR_POLY(8'h8E), .CAPTURE_LATENCY(RL), .EXPECTED_SIGNATURE(8'h00)) dut_r (
        .CLOCK(clk), .RESET_N(rst_n), .START(start_r), .PATTERN_OUT(pat_r), .PATTERN_VALID(pv_r),
        .RESPONSE_IN(resp_r), .BUSY(busy_r), .DONE(done_r), .SIGNATURE(sig_r)
`ifdef BIST_SIGNATURE_CHECK_EN
       ,.PASS(pass_r)
`endif
    );

    // Galois step straight from its arithmetic definition: halve, then fold in the mask if odd.
    function automatic logic [31:0] gstep(input logic [31:0] x, input logic [31:0] p);
        return (x / 2) ^ ((x % 2 == 1) ? p : 32'd0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_tests++;
        if (pat_a !== 4'h0 || pv_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_a: got pat=%h valid=%b busy=%b done=%b sig=%h, expected all zero",
                     pat_a, pv_a, busy_a, done_a, sig_a);
        end
        n_tests++;
        if (pv_c !== 1'b0 || busy_c !== 1'b0 || done_c !== 1'b0 || sig_c !== 4'h0 ||
            pv_r !== 1'b0 || busy_r !== 1'b0 || done_r !== 1'b0 || sig_r !== 8'h00 || pat_r !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_cr: got c(v=%b b=%b d=%b s=%h) r(p=%h v=%b b=%b d=%b s=%h), expected all zero",
                     pv_c, busy_c, done_c, sig_c, pat_r, pv_r, busy_r, done_r, sig_r);
        end
`ifdef BIST_SIGNATURE_CHECK_EN
        n_tests++;
        if (pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pass: got %b, expected 0", pass_a);
        end
`endif
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_scenario2(input string tag);
        logic [3:0] exp_pat [4] = '{4'h1, 4'hC, 4'h6, 4'h3};
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (pat_a !== exp_pat[k] || pv_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_pattern%0d: got pat=%h valid=%b busy=%b done=%b, expected pat=%h valid=1 busy=1 done=0",
                         tag, k, pat_a, pv_a, busy_a, done_a, exp_pat[k]);
            end
            tick;
        end
        n_tests++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || pv_a !== 1'b0 || pat_a !== 4'h0) begin
            n_fail++;
            $display("FAIL %s_done_cycle5: got done=%b busy=%b valid=%b pat=%h, expected done=1 busy=0 valid=0 pat=0",
                     tag, done_a, busy_a, pv_a, pat_a);
        end
        n_tests++;
        if (sig_a !== 4'h5) begin
            n_fail++;
            $display("FAIL %s_signature: got %h, expected 5", tag, sig_a);
        end
`ifdef BIST_SIGNATURE_CHECK_EN
        n_tests++;
        if (pass_a !== 1'b1 || pass_a6 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pass: got pass(exp5)=%b pass(exp6)=%b, expected 1 and 0", tag, pass_a, pass_a6);
        end
`endif
    endtask

    task automatic test_period;
        logic [3:0] m = 4'h1;
        logic [3:0] ms = 4'h0;
        logic [3:0] inv;
        logic [3:0] held;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (pat_b !== m || pv_b !== 1'b1 || done_b !== 1'b0) begin
                n_fail++;
                $display("FAIL period_pattern%0d: got pat=%h valid=%b done=%b, expected pat=%h valid=1 done=0",
                         k, pat_b, pv_b, done_b, m);
            end
            if (k == 15) begin
                n_tests++;
                if (pat_b !== 4'h1) begin
                    n_fail++;
                    $display("FAIL period_wrap: got pattern15=%h, expected 1", pat_b);
                end
            end
            inv = ~m;
            ms  = 4'(gstep(ms, 4'hC)) ^ inv;
            m   = 4'(gstep(m, 4'hC));
            tick;
        end
        n_tests++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || sig_b !== ms) begin
            n_fail++;
            $display("FAIL period_done17: got done=%b busy=%b sig=%h, expected done=1 busy=0 sig=%h",
                     done_b, busy_b, sig_b, ms);
        end
        held = ms;
        tick;
        tick;
        n_tests++;
        if (done_b !== 1'b1 || sig_b !== held) begin
            n_fail++;
            $display("FAIL period_hold: got done=%b sig=%h, expected done=1 sig=%h", done_b, sig_b, held);
        end
    endtask

    task automatic test_latency;
        logic [3:0] m = 4'h1;
        int first_done = 0;
        start_c = 1'b1;
        tick;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (done_c === 1'b1) begin
                first_done = cyc;
                start_c = 1'b0;
                break;
            end
            n_tests++;
            if (cyc <= 4) begin
                if (pat_c !== m || pv_c !== 1'b1 || busy_c !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency_pattern_cyc%0d: got pat=%h valid=%b busy=%b, expected pat=%h valid=1 busy=1",
                             cyc, pat_c, pv_c, busy_c, m);
                end
                m = 4'(gstep(m, 4'hC));
            end else if (pv_c !== 1'b0 || busy_c !== 1'b1 || pat_c !== 4'h0) begin
                n_fail++;
                $display("FAIL latency_drain_cyc%0d: got pat=%h valid=%b busy=%b, expected pat=0 valid=0 busy=1",
                         cyc, pat_c, pv_c, busy_c);
            end
            tick;
        end
        start_c = 1'b0;
        n_tests++;
        if (first_done != 7) begin
            n_fail++;
            $display("FAIL latency_done_cycle: got first DONE at cycle %0d (0 = none within bound), expected 7", first_done);
        end
        n_tests++;
        if (sig_c !== 4'h5) begin
            n_fail++;
            $display("FAIL latency_signature: got %h, expected 5", sig_c);
        end
        tick;
        n_tests++;
        if (done_c !== 1'b1 || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_hold: got done=%b busy=%b, expected done=1 busy=0", done_c, busy_c);
        end
    endtask

    task automatic test_reset_midrun;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        tick;
        tick;
        n_tests++;
        if (pat_a !== 4'h6) begin
            n_fail++;
            $display("FAIL midrun_pattern2: got %h, expected 6", pat_a);
        end
        rst_n = 1'b0;
        tick;
        n_tests++;
        if (pat_a !== 4'h0 || pv_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 4'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: got pat=%h valid=%b busy=%b done=%b sig=%h, expected all zero",
                     pat_a, pv_a, busy_a, done_a, sig_a);
        end
        rst_n = 1'b1;
        tick;
        test_scenario2("after_reset");
    endtask

    task automatic test_random;
        logic [RW-1:0] resp_hist [0:RN+RL+1];
        logic [RW-1:0] mp, ms, held;
        int hold;
        for (int run = 0; run < 5; run++) begin
            repeat ($urandom_range(0, 4)) begin
                resp_r = RW'($urandom);
                tick;
            end
            hold   = $urandom_range(1, 3);
            mp     = 8'h5A;
            start_r = 1'b1;
            resp_r = RW'($urandom);
            tick;
            for (int c = 1; c <= RN + RL + 1; c++) begin
                if (c > hold) start_r = 1'b0;
                resp_r       = RW'($urandom);
                resp_hist[c] = resp_r;
                n_tests++;
                if (c <= RN) begin
                    if (pat_r !== mp || pv_r !== 1'b1 || busy_r !== 1'b1 || done_r !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand%0d_pattern_cyc%0d: got pat=%h valid=%b busy=%b done=%b, expected pat=%h 1 1 0",
                                 run, c, pat_r, pv_r, busy_r, done_r, mp);
                    end
                    mp = RW'(gstep(mp, 8'hB8));
                end else if (c <= RN + RL) begin
                    if (pat_r !== '0 || pv_r !== 1'b0 || busy_r !== 1'b1 || done_r !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand%0d_drain_cyc%0d: got pat=%h valid=%b busy=%b done=%b, expected 0 0 1 0",
                                 run, c, pat_r, pv_r, busy_r, done_r);
                    end
                end else if (done_r !== 1'b1 || busy_r !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand%0d_done: got done=%b busy=%b at cycle %0d, expected done=1 busy=0",
                             run, done_r, busy_r, c);
                end
                if (c <= RN + RL) tick;
            end
            ms = '0;
            for (int k = 0; k < RN; k++) begin
                ms = RW'(gstep(ms, 8'h8E)) ^ resp_hist[k + 1 + RL];
            end
            n_tests++;
            if (sig_r !== ms) begin
                n_fail++;
                $display("FAIL rand%0d_signature: got %h, expected %h", run, sig_r, ms);
            end
            held   = ms;
            resp_r = RW'($urandom);
            tick;
            n_tests++;
            if (sig_r !== held || done_r !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_frozen: got sig=%h done=%b, expected sig=%h done=1", run, sig_r, done_r, held);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_r = 1'b0;
        resp_r  = '0;
        test_reset;
        test_scenario2("basic");
        test_scenario2("back_to_back");
        test_period;
        test_latency;
        test_reset_midrun;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
